// File: rtl/sar_busca_12_pkg.sv
// sga_pkg: shared state encoding and default sizing for the SAR search controller
package sga_pkg;
  localparam int SGA_WIDTH  = 12;
  localparam int SGA_SETTLE = 1;
  localparam logic [2:0] OCIOSO = 3'd0;
  localparam logic [2:0] APLICA = 3'd1;
  localparam logic [2:0] ESPERA = 3'd2;
  localparam logic [2:0] DECIDE = 3'd3;
  localparam logic [2:0] FIM    = 3'd4;
  localparam logic [2:0] ERRO   = 3'd5;
endpackage

// File: rtl/sar_busca_12_if.sv
// sar_busca_12_if: start/status handshake plus comparator trial operand and flags
interface sar_busca_12_if #(parameter int WIDTH = 12);
  logic             iniciar;
  logic             alb;
  logic             agb;
  logic             aeb;
  logic [WIDTH-1:0] trial;
  logic [WIDTH-1:0] valor;
  logic             ocupado;
  logic             pronto;
  logic             erro;
  modport master (output iniciar, alb, agb, aeb, input trial, valor, ocupado, pronto, erro);
  modport slave  (input iniciar, alb, agb, aeb, output trial, valor, ocupado, pronto, erro);
endinterface

// File: rtl/sar_busca_12_contador_espera.sv
// contador_espera: loadable 4-bit down-counter with zero flag for comparator settling
module contador_espera (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       load,
  input  logic       en,
  input  logic [3:0] value,
  output logic       zero
);
  logic [3:0] cnt;
  // load wins; otherwise count down and park at zero
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (load) cnt <= value;
    else if (en && cnt != 4'd0) cnt <= cnt - 4'd1;
  assign zero = cnt == 4'd0;
endmodule

// File: rtl/sar_busca_12.sv
// sar_busca_12: binary-search controller driving an external magnitude comparator
module sar_busca_12
  import sga_pkg::*;
#(
  parameter int WIDTH  = SGA_WIDTH,
  parameter int SETTLE = SGA_SETTLE
) (
  input logic clock,
  input logic reset_n,
  sar_busca_12_if.slave bus
);
  localparam logic [WIDTH-1:0] MSB  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [3:0]       LOAD = 4'(SETTLE - 1);
  logic [2:0]       state;
  logic [WIDTH-1:0] trial, valor, result, mask;
  logic             zero;
  logic             sane;
  assign sane = $onehot({bus.alb, bus.agb, bus.aeb});
  contador_espera u_espera (
    .clock  (clock),
    .reset_n(reset_n),
    .load   (state == APLICA),
    .en     (state == ESPERA),
    .value  (LOAD),
    .zero   (zero)
  );
  // search FSM: apply trial, let the comparator settle, then keep or drop the bit
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state  <= OCIOSO;
      trial  <= '0;
      valor  <= '0;
      result <= '0;
      mask   <= '0;
    end else
      case (state)
        OCIOSO, ERRO:
          if (bus.iniciar) begin
            result <= '0;
            mask   <= MSB;
            state  <= APLICA;
          end
        APLICA: begin
          trial <= result | mask;
          state <= ESPERA;
        end
        ESPERA: if (zero) state <= DECIDE;
        DECIDE:
          if (!sane) state <= ERRO;
          else if (bus.aeb) begin
            valor <= trial;
            state <= FIM;
          end else begin
            if (bus.agb) result <= trial;
            if (mask == WIDTH'(1)) begin
              valor <= bus.agb ? trial : result;
              state <= FIM;
            end else begin
              mask  <= mask >> 1;
              state <= APLICA;
            end
          end
        default: state <= OCIOSO;
      endcase
  assign bus.trial   = trial;
  assign bus.valor   = valor;
  assign bus.ocupado = state == APLICA || state == ESPERA || state == DECIDE;
  assign bus.pronto  = state == FIM;
  assign bus.erro    = state == ERRO;
endmodule
